// File: rtl/aes_pkg.sv
// Shared AES types, round constants and GF(2^8) helpers used by the
// encryption and decryption round-key stages.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam byte_t AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } stage_state_e;

  typedef struct packed {
    logic [127:0] state;
    logic [127:0] key;
    byte_t        rcon;
    logic [3:0]   round;
  } stage_item_t;

  function automatic byte_t xtime(byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // Odd inputs came from a byte whose top bit was set before the 0x1B reduction.
  function automatic byte_t inv_xtime(byte_t r);
    return r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a purely combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/inv_addroundkey_stage.sv
// Decryption round-key stage: state ^= K[r], key schedule stepped back to
// K[r-1], Rcon stepped back; registered output with a one-entry skid buffer.
module inv_addroundkey_stage
  import aes_pkg::*;
#(
  parameter logic [127:0] RESET_DATA = 128'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         empty_in,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  input  logic [3:0]   round_in,
  input  logic         stall,
  output logic         busy,
  output logic         empty,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [7:0]   rcon_out,
  output logic [3:0]   round_out,
  output logic         err
);

  word_t        w0, w1, w2, w3;
  word_t        p0, p1, p2, p3;
  word_t        rot_w, sub_w;
  stage_item_t  item_d;
  stage_item_t  out_q, skid_q;
  stage_state_e st_q;
  logic         err_q;
  logic         offer, accept, drain, bad_round, skid_load;

  // Combinational compute stage, ahead of the out/skid registers
  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign p3    = w3 ^ w2;
  assign p2    = w2 ^ w1;
  assign p1    = w1 ^ w0;
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a_i(rot_w[8*i +: 8]),
      .s_o(sub_w[8*i +: 8])
    );
  end

  assign p0 = w0 ^ sub_w ^ {rcon_in, 24'h0};

  assign item_d.state = state_in ^ key_in;
  assign item_d.key   = {p0, p1, p2, p3};
  assign item_d.rcon  = inv_xtime(rcon_in);
  assign item_d.round = round_in - 4'd1;

  assign busy      = (st_q == ST_TWO);
  assign empty     = (st_q == ST_EMPTY);
  assign offer     = !empty_in && !busy;
  assign accept    = offer && (round_in != 4'd0);
  assign bad_round = offer && (round_in == 4'd0);
  assign drain     = !empty && !stall;
  assign skid_load = (st_q == ST_ONE) && accept && !drain;

  // Output register stage: occupancy FSM, visible item and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= ST_EMPTY;
      err_q       <= 1'b0;
      out_q.state <= RESET_DATA;
      out_q.key   <= RESET_DATA;
      out_q.rcon  <= 8'h00;
      out_q.round <= 4'd0;
    end else begin
      if (bad_round) err_q <= 1'b1;
      case (st_q)
        ST_EMPTY: begin
          if (accept) begin
            st_q  <= ST_ONE;
            out_q <= item_d;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_q <= item_d;
          end else if (accept) begin
            st_q <= ST_TWO;
          end else if (drain) begin
            st_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            st_q  <= ST_ONE;
            out_q <= skid_q;
          end
        end
        default: st_q <= ST_EMPTY;
      endcase
    end
  end

  // Skid register stage: contents are only meaningful while st_q == ST_TWO
  always_ff @(posedge clock) begin
    if (skid_load) skid_q <= item_d;
  end

  assign state_out = out_q.state;
  assign key_out   = out_q.key;
  assign rcon_out  = out_q.rcon;
  assign round_out = out_q.round;
  assign err       = err_q;

endmodule

// File: tb/tb_inv_addroundkey_stage.sv
// Bench for inv_addroundkey_stage: directed key-schedule vectors, stall/skid
// scenarios, reset and a randomized run against a queue-based reference.
module tb_inv_addroundkey_stage;

  typedef struct {
    logic [127:0] st;
    logic [127:0] k;
    logic [7:0]   rc;
    logic [3:0]   rd;
  } ref_item_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         empty_in;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [7:0]   rcon_in;
  logic [3:0]   round_in;
  logic         stall;
  logic         busy, empty, err;
  logic [127:0] state_out, key_out;
  logic [7:0]   rcon_out;
  logic [3:0]   round_out;

  int n_chk  = 0;
  int n_fail = 0;

  ref_item_t q[$];
  ref_item_t shown;
  ref_item_t rst_item;
  logic      err_m;

  inv_addroundkey_stage #(.RESET_DATA(128'h0)) dut (
    .clock(clock), .reset(reset), .empty_in(empty_in), .state_in(state_in),
    .key_in(key_in), .rcon_in(rcon_in), .round_in(round_in), .stall(stall),
    .busy(busy), .empty(empty), .state_out(state_out), .key_out(key_out),
    .rcon_out(rcon_out), .round_out(round_out), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    logic [7:0] c = 8'h63;
    for (int i = 1; i < 256; i++)
      if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] inv_xtime_ref(input logic [7:0] r);
    logic [7:0] res = 8'h00;
    for (int i = 0; i < 256; i++)
      if (gmul(8'(i), 8'h02) == r) res = 8'(i);
    return res;
  endfunction

  function automatic ref_item_t model(input logic [127:0] s, input logic [127:0] k,
                                      input logic [7:0] rc, input logic [3:0] rd);
    ref_item_t it;
    logic [31:0] w [4];
    logic [31:0] p [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 1; i < 4; i++) p[i] = w[i] ^ w[i-1];
    t = {p[3][23:0], p[3][31:24]};
    for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox_ref(t[8*i +: 8]);
    p[0] = w[0] ^ t ^ {rc, 24'h0};
    it.st = s ^ k;
    it.k  = {p[0], p[1], p[2], p[3]};
    it.rc = inv_xtime_ref(rc);
    it.rd = rd - 4'd1;
    return it;
  endfunction

  task automatic cycle();
    logic      acc, drn, bad;
    ref_item_t nxt;
    if (reset) begin
      @(posedge clock);
      q.delete();
      err_m = 1'b0;
      shown = rst_item;
    end else begin
      drn = (q.size() != 0) && !stall;
      acc = !empty_in && (q.size() != 2) && (round_in != 4'd0);
      bad = !empty_in && (q.size() != 2) && (round_in == 4'd0);
      nxt = model(state_in, key_in, rcon_in, round_in);
      @(posedge clock);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(nxt);
      if (bad) err_m = 1'b1;
      if (q.size() != 0) shown = q[0];
    end
    #1;
    check("empty", empty, (q.size() == 0));
    check("busy", busy, (q.size() == 2));
    check("err", err, err_m);
    check("state_out", state_out, shown.st);
    check("key_out", key_out, shown.k);
    check("rcon_out", rcon_out, shown.rc);
    check("round_out", round_out, shown.rd);
  endtask

  task automatic offer(input logic [127:0] s, input logic [127:0] k,
                       input logic [7:0] rc, input logic [3:0] rd);
    empty_in = 1'b0;
    state_in = s;
    key_in   = k;
    rcon_in  = rc;
    round_in = rd;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [7:0] rcon_seq [10];
    rcon_seq = '{8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h8D};
    rst_item = '{st: 128'h0, k: 128'h0, rc: 8'h00, rd: 4'd0};
    shown    = rst_item;
    err_m    = 1'b0;
    reset    = 1'b1;
    stall    = 1'b0;
    empty_in = 1'b1;
    state_in = '0;
    key_in   = '0;
    rcon_in  = '0;
    round_in = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // FIPS-197 K10 -> K9
    offer(128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 8'h36, 4'd10);
    cycle();
    check("t1_key", key_out, 128'hac7766f319fadc2128d12941575c006e);
    check("t1_rcon", rcon_out, 8'h1B);
    check("t1_round", round_out, 4'd9);

    // K1 -> K0, Rcon wraps backwards to 8D
    offer(128'h0, 128'ha0fafe1788542cb123a339392a6c7605, 8'h01, 4'd1);
    cycle();
    check("t2_key", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("t2_rcon", rcon_out, 8'h8D);

    offer(128'h000102030405060708090A0B0C0D0E0F, 128'h0102030405060708090A0B040C0D0E0F, 8'h02, 4'd3);
    cycle();
    check("t3_state", state_out, 128'h0103010701030107010301_0F00000000 >> 0 == 0 ? 128'h0 : 128'h010301070103010F0103010F00000000);
    empty_in = 1'b1;
    cycle();

    // A, B, C offered back-to-back under a 3-cycle stall
    stall = 1'b1;
    offer(rnd128(), rnd128(), 8'h10, 4'd5);
    cycle();
    offer(rnd128(), rnd128(), 8'h20, 4'd6);
    cycle();
    check("t4_busy", busy, 1'b1);
    offer(rnd128(), rnd128(), 8'h40, 4'd7);
    cycle();
    check("t4_held_round", round_out, 4'd4);
    stall = 1'b0;
    cycle();
    check("t4_b_round", round_out, 4'd5);
    cycle();
    check("t4_c_round", round_out, 4'd6);
    empty_in = 1'b1;
    cycle();
    check("t4_empty", empty, 1'b1);

    // Zero round: dropped and sticky error
    offer(rnd128(), rnd128(), 8'h01, 4'd0);
    cycle();
    check("t5_err", err, 1'b1);
    check("t5_empty", empty, 1'b1);
    empty_in = 1'b1;
    cycle();
    check("t5_err_sticky", err, 1'b1);
    stall = 1'b1;
    offer(rnd128(), rnd128(), 8'h04, 4'd2);
    cycle();
    offer(rnd128(), rnd128(), 8'h08, 4'd3);
    cycle();
    empty_in = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    stall = 1'b0;
    check("t5_rst_empty", empty, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_err", err, 1'b0);

    // Ten-round chain, each output fed straight back as the next input
    offer(rnd128(), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 8'h36, 4'd10);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t6_no_bubble", empty, 1'b0);
      check("t6_rcon", rcon_out, rcon_seq[i]);
      offer(state_out, key_out, rcon_out, round_out);
    end
    check("t6_k0", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("t6_round0", round_out, 4'd0);
    empty_in = 1'b1;
    cycle();

    // Randomized traffic with random stalls and occasional zero rounds
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 9) < 4);
      empty_in = ($urandom_range(0, 9) < 3);
      state_in = rnd128();
      key_in   = rnd128();
      rcon_in  = 8'($urandom);
      round_in = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 10));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
